pll_lock_monitor: RTL and testbench
===================================

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for lock_i.
REQ-002 The block SHALL have parameter PLL_RST_CYCLES, default 8: length of each pll_rst_o pulse, in cycles.
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 1000: number of cycles to wait for lock before retrying the PLL reset.
REQ-004 The block SHALL have parameter STABLE_CYCLES, default 16: number of consecutive synchronized-lock cycles required before reset release.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, the PLL reference clock domain.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port lock_i, input, 1 bit: PLL LOCK, asynchronous to clk.
REQ-008 The block SHALL have port pll_rst_o, output, 1 bit: drives the PLL RESET pin, active-high.
REQ-009 The block SHALL have port sys_rst_o, output, 1 bit: synchronous active-high reset for downstream logic.
REQ-010 The block SHALL have port locked_o, output, 1 bit: high when lock is qualified.
REQ-011 The block SHALL have port loss_cnt_o, output, 8 bits: saturating count of lock-loss events.

Function
REQ-012 lock_i SHALL pass through SYNC_STAGES flops before use, giving lock_s; no other logic SHALL read lock_i.
REQ-013 The FSM SHALL have four states: PLL_RST, WAIT_LOCK, STABLE, RUN; a single cycle counter SHALL be cleared on every state change.
REQ-014 In PLL_RST, pll_rst_o SHALL be 1; after PLL_RST_CYCLES cycles the FSM SHALL move to WAIT_LOCK.
REQ-015 In WAIT_LOCK, lock_s=1 SHALL move the FSM to STABLE; if the counter reaches LOCK_TIMEOUT-1 with lock_s=0, the FSM SHALL move to PLL_RST (retry).
REQ-016 In STABLE, lock_s=0 SHALL move the FSM to WAIT_LOCK with the timeout restarted; after STABLE_CYCLES consecutive cycles of lock_s=1, the FSM SHALL move to RUN.
REQ-017 In RUN, lock_s=0 SHALL move the FSM to WAIT_LOCK and increment loss_cnt_o, saturating at 255.
REQ-018 All outputs SHALL be registered; sys_rst_o=0 and locked_o=1 only while in RUN; in every other state sys_rst_o=1 and locked_o=0.
REQ-019 sys_rst_o SHALL fall exactly SYNC_STAGES+STABLE_CYCLES+1 clk edges after the first edge that samples lock_i=1 in WAIT_LOCK, provided lock_i stays high.
REQ-020 sys_rst_o SHALL rise SYNC_STAGES+1 edges after the first edge that samples lock_i=0 in RUN.
REQ-021 Glitches on lock_i shorter than the qualify window SHALL never deassert sys_rst_o.
REQ-022 The counter width SHALL fit max(LOCK_TIMEOUT, PLL_RST_CYCLES, STABLE_CYCLES) and SHALL never wrap.

Reset
REQ-023 rst=1 SHALL, on the next edge, force the FSM to PLL_RST with the counter at 0, pll_rst_o=1, sys_rst_o=1, locked_o=0, loss_cnt_o=0 and the synchronizer flops at 0, including when rst is asserted mid-RUN.
REQ-024 rst SHALL take priority over every FSM transition in the same cycle.

Configuration
REQ-025 Macro PLL_LOCK_MON_STATS_EN defined: loss_cnt_o SHALL be implemented per REQ-017.
REQ-026 Macro PLL_LOCK_MON_STATS_EN undefined: loss_cnt_o SHALL be constant 0 and no counter register SHALL exist; all other behaviour SHALL be unchanged.

Structure
REQ-027 Package pll_mon_pkg SHALL hold the FSM state enum type and a function computing the counter width.
REQ-028 The synchronizer SHALL be a sub-module, lock_sync, parameterized by SYNC_STAGES.

Verification (default parameters)
REQ-029 Reset then lock_i=1 from cycle 0 -> pll_rst_o high for 8 cycles; sys_rst_o falls 19 edges after the first WAIT_LOCK edge; locked_o=1.
REQ-030 lock_i held at 0 -> pll_rst_o re-pulses for 8 cycles every 1008 cycles; sys_rst_o stays 1.
REQ-031 In STABLE, a 3-cycle lock_i low glitch -> FSM returns to WAIT_LOCK; sys_rst_o stays 1; the qualify window restarts.
REQ-032 In RUN, lock_i falls -> sys_rst_o=1 and locked_o=0 three edges later; loss_cnt_o=1; after 300 loss events, loss_cnt_o=255.
REQ-033 rst pulsed mid-RUN -> all outputs at reset values next edge, loss_cnt_o=0; rebuild without the macro -> loss_cnt_o=0 throughout.

Source files
------------

// File: rtl/pll_mon_pkg.sv
// pll_mon_pkg: FSM state type and counter sizing shared by pll_lock_monitor.
package pll_mon_pkg;
   typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABLE, RUN} state_t;
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction
endpackage

// File: rtl/lock_sync.sv
// lock_sync: SYNC_STAGES-deep flop chain bringing the asynchronous PLL lock into clk.
module lock_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [SYNC_STAGES-1:0] ff;
   always_ff @(posedge clk)
      if (rst) ff <= '0;
      else begin
         ff[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) ff[i] <= ff[i-1];
      end
   assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/pll_lock_monitor.sv
// pll_lock_monitor: pulses PLL reset, qualifies lock, then releases downstream reset.
// Define PLL_LOCK_MON_STATS_EN to build the saturating lock-loss counter.
module pll_lock_monitor
   import pll_mon_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES = 8,
   parameter int LOCK_TIMEOUT   = 1000,
   parameter int STABLE_CYCLES  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lock_i,
   output logic       pll_rst_o,
   output logic       sys_rst_o,
   output logic       locked_o,
   output logic [7:0] loss_cnt_o
);
   localparam int CW = cnt_width(LOCK_TIMEOUT, PLL_RST_CYCLES, STABLE_CYCLES);
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic lock_s;
   lock_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (lock_i),
      .q  (lock_s)
   );
   always_comb
      case (state)
         PLL_RST:   nxt = (cnt == CW'(PLL_RST_CYCLES - 1)) ? WAIT_LOCK : PLL_RST;
         WAIT_LOCK: nxt = lock_s ? STABLE : (cnt == CW'(LOCK_TIMEOUT - 1)) ? PLL_RST : WAIT_LOCK;
         STABLE:    nxt = !lock_s ? WAIT_LOCK : (cnt == CW'(STABLE_CYCLES - 1)) ? RUN : STABLE;
         default:   nxt = lock_s ? RUN : WAIT_LOCK;
      endcase
   // Outputs are registered from the next state so they change on the same edge as the FSM.
   always_ff @(posedge clk)
      if (rst) begin
         state     <= PLL_RST;
         cnt       <= '0;
         pll_rst_o <= 1'b1;
         sys_rst_o <= 1'b1;
         locked_o  <= 1'b0;
      end else begin
         state     <= nxt;
         cnt       <= (nxt != state || state == RUN) ? '0 : cnt + 1'b1;
         pll_rst_o <= nxt == PLL_RST;
         sys_rst_o <= nxt != RUN;
         locked_o  <= nxt == RUN;
      end
`ifdef PLL_LOCK_MON_STATS_EN
   always_ff @(posedge clk)
      if (rst) loss_cnt_o <= '0;
      else if (state == RUN && !lock_s && loss_cnt_o != 8'hff) loss_cnt_o <= loss_cnt_o + 8'd1;
`else
   assign loss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb_pll_lock_monitor: table vectors, corner sequences and random lock traffic vs an elapsed-time model.
module tb_pll_lock_monitor;
   localparam int SYNC = 2, PRC = 8, TO = 1000, SC = 16;
`ifdef PLL_LOCK_MON_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, lock_i = 1'b0;
   logic pll_rst_o, sys_rst_o, locked_o;
   logic [7:0] loss_cnt_o;
   int n_vec = 0, n_bad = 0;
   int m_ph, m_t, m_loss;
   bit mq[$];
   pll_lock_monitor dut (
      .clk       (clk),
      .rst       (rst),
      .lock_i    (lock_i),
      .pll_rst_o (pll_rst_o),
      .sys_rst_o (sys_rst_o),
      .locked_o  (locked_o),
      .loss_cnt_o(loss_cnt_o)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Reference: phase 0..3 = pulse/wait/qualify/run, m_t = edges spent in the phase,
   // mq holds the raw lock samples still in flight through the synchronizer.
   task automatic go(input int ph);
      m_ph = ph;
      m_t  = 0;
   endtask
   task automatic model_edge(input bit r, input bit l);
      bit ls;
      if (r) begin
         go(0);
         m_loss = 0;
         mq = {};
         repeat (SYNC) mq.push_back(1'b0);
         return;
      end
      ls = mq[SYNC-1];
      m_t++;
      case (m_ph)
         0: if (m_t == PRC) go(1);
         1: if (ls) go(2); else if (m_t == TO) go(0);
         2: if (!ls) go(1); else if (m_t == SC) go(3);
         default: if (!ls) begin
            go(1);
            if (m_loss < 255) m_loss++;
         end
      endcase
      mq.push_front(l);
      void'(mq.pop_back());
   endtask
   task automatic tick(input bit r, input bit l);
      logic [7:0] el;
      rst = r;
      lock_i = l;
      @(posedge clk);
      model_edge(r, l);
      #1;
      el = STATS ? 8'(m_loss) : 8'd0;
      chk("model", {pll_rst_o, sys_rst_o, locked_o, loss_cnt_o},
          {m_ph == 0, m_ph != 3, m_ph == 3, el});
   endtask
   typedef struct {bit r; bit l; int n; bit pll; bit sys; bit lk;} seg_t;
   seg_t tbl[7];
   initial begin
      tbl[0] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 7,  1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 17, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 5,  1'b0, 1'b1, 1'b0};
      #2;
      for (int s = 0; s < 7; s++)
         for (int c = 0; c < tbl[s].n; c++) begin
            tick(tbl[s].r, tbl[s].l);
            chk($sformatf("tbl%0d", s), {pll_rst_o, sys_rst_o, locked_o}, {tbl[s].pll, tbl[s].sys, tbl[s].lk});
         end
      chk("loss_after_drop", loss_cnt_o, STATS ? 1 : 0);
      // Lock rises in WAIT_LOCK: release on the 19th edge counting the first sampling edge.
      tick(1'b1, 1'b0);
      chk("reset_vals", {pll_rst_o, sys_rst_o, locked_o, loss_cnt_o}, {3'b110, 8'd0});
      repeat (13) tick(1'b0, 1'b0);
      for (int k = 0; k <= 18; k++) begin
         tick(1'b0, 1'b1);
         chk("qualify", {sys_rst_o, locked_o}, {k < 18, k == 18});
      end
      // Lock drops in RUN: reset reasserts on the third edge.
      for (int k = 0; k <= 2; k++) begin
         tick(1'b0, 1'b0);
         chk("drop", {sys_rst_o, locked_o}, {k == 2, k != 2});
      end
      chk("loss_one", loss_cnt_o, STATS ? 1 : 0);
      // Three-cycle glitch while qualifying restarts the full window.
      repeat (5) tick(1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b0);
         chk("glitch", sys_rst_o, 1);
      end
      for (int k = 0; k <= 18; k++) begin
         tick(1'b0, 1'b1);
         chk("requalify", sys_rst_o, k < 18);
      end
      // No lock: PLL reset re-pulses every PRC+TO cycles.
      for (int k = 0; k <= 2100; k++) begin
         tick(k == 0, 1'b0);
         chk("retry", {pll_rst_o, sys_rst_o}, {(k % (PRC + TO)) < PRC, 1'b1});
      end
      repeat (20) tick(1'b0, 1'b1);
      chk("run_again", locked_o, 1);
      for (int e = 0; e < 300; e++) begin
         repeat (3) tick(1'b0, 1'b0);
         repeat (20) tick(1'b0, 1'b1);
      end
      chk("loss_sat", loss_cnt_o, STATS ? 255 : 0);
      tick(1'b1, 1'b1);
      chk("rst_mid_run", {pll_rst_o, sys_rst_o, locked_o, loss_cnt_o}, {3'b110, 8'd0});
      // Random lock traffic with runs of varying length and rare resets.
      for (int c = 0; c < 4000;) begin
         int len;
         bit l;
         len = $urandom_range(1, 40);
         l = 1'($urandom_range(0, 1));
         for (int j = 0; j < len; j++) tick($urandom_range(0, 499) == 0, l);
         c += len;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
